video_capture: RTL and testbench



---
 rtl/video_capture_pkg.sv | 19 +
 rtl/video_capture_if.sv | 28 ++
 rtl/video_capture_sync_edge_det.sv | 22 ++
 rtl/video_capture.sv | 154 +++++++++++++++
 tb/tb_video_capture.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/video_capture_pkg.sv
// Shared capture types: timing-recovery states and the {G,R,B} pixel packing.
// Pure declarations, no latency.
// No flow control involved.
package vce_capture_pkg;

  typedef enum logic [1:0] {
    CAP_SEEK,
    CAP_MEASURE,
    CAP_LOCK
  } cap_state_t;

  typedef logic [2:0] color_t;
  typedef logic [8:0] grb_t;

  function automatic grb_t pack_grb(input color_t r, input color_t g, input color_t b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/video_capture_if.sv
// Video input bus (pixel strobe, RGB, syncs) plus frame-buffer write port.
// Wires only, no latency.
// No backpressure: the write port is fire-and-forget.
interface video_capture_if
  import vce_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);
  logic              pix_en;
  color_t            VIDEO_R;
  color_t            VIDEO_G;
  color_t            VIDEO_B;
  logic              HSYNC_n;
  logic              VSYNC_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  grb_t              wr_data;

  modport master (
    output pix_en, VIDEO_R, VIDEO_G, VIDEO_B, HSYNC_n, VSYNC_n,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pix_en, VIDEO_R, VIDEO_G, VIDEO_B, HSYNC_n, VSYNC_n,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/video_capture_sync_edge_det.sv
// Falling-edge detector for an active-low sync, advancing only on pix_en.
// Fall is combinational in the sampling cycle; history updates at the edge.
// No backpressure; idle cycles (pix_en low) are simply ignored.
module sync_edge_det (
  input  logic clock,
  input  logic reset_N,
  input  logic pix_en,
  input  logic sync_n,
  output logic fall
);
  logic hist;

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      hist <= 1'b1;
    end else if (pix_en) begin
      hist <= sync_n;
    end
  end

  assign fall = pix_en & hist & ~sync_n;
endmodule

// File: rtl/video_capture.sv
// Recovers line/frame timing from VCE syncs and writes active pixels to a frame buffer.
// Write port and measurements are registered one clock after the pix_en sample.
// No backpressure: the frame buffer must accept one write per enabled pixel.
module video_capture
  import vce_capture_pkg::*;
#(
  parameter int unsigned H_START = 16,
  parameter int unsigned H_LEN   = 256,
  parameter int unsigned V_START = 14,
  parameter int unsigned V_LEN   = 240,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic               clock,
  input  logic               reset_N,
  video_capture_if.slave     vid,
  output logic [CNT_W-1:0]   line_len,
  output logic [CNT_W-1:0]   frame_lines,
  output logic               frame_done,
  output logic               locked,
  output logic [7:0]         frame_cnt
);
  localparam int unsigned       PIX_TOTAL = H_LEN * V_LEN;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIX_TOTAL - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  H_LO      = CNT_W'(H_START);
  localparam logic [CNT_W-1:0]  H_HI      = CNT_W'(H_START + H_LEN);
  localparam logic [CNT_W-1:0]  V_LO      = CNT_W'(V_START);
  localparam logic [CNT_W-1:0]  V_HI      = CNT_W'(V_START + V_LEN);

  cap_state_t        state, state_nxt;
  logic              h_fall, v_fall;
  logic [CNT_W-1:0]  hcnt, vcnt;
  logic [CNT_W-1:0]  line_len_nxt, frame_lines_nxt;
  logic [CNT_W-1:0]  prev_line_len, prev_frame_lines;
  logic              meas_match;
  logic [ADDR_W-1:0] wr_ptr;
  logic              ptr_done;
  logic              in_win, wr_qual;

  sync_edge_det u_h_edge (
    .clock   (clock),
    .reset_N (reset_N),
    .pix_en  (vid.pix_en),
    .sync_n  (vid.HSYNC_n),
    .fall    (h_fall)
  );

  sync_edge_det u_v_edge (
    .clock   (clock),
    .reset_N (reset_N),
    .pix_en  (vid.pix_en),
    .sync_n  (vid.VSYNC_n),
    .fall    (v_fall)
  );

  assign line_len_nxt    = h_fall ? hcnt + CNT_ONE : line_len;
  assign frame_lines_nxt = vcnt + CNT_ONE;
  assign meas_match      = (line_len_nxt == prev_line_len) &&
                           (frame_lines_nxt == prev_frame_lines);

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      hcnt        <= '0;
      vcnt        <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else if (vid.pix_en) begin
      if (h_fall) begin
        hcnt     <= '0;
        line_len <= line_len_nxt;
      end else if (hcnt != CNT_MAX) begin
        hcnt <= hcnt + CNT_ONE;
      end
      // A coincident V fall wins, so the first line of a frame is line 0.
      if (v_fall) begin
        vcnt        <= '0;
        frame_lines <= frame_lines_nxt;
      end else if (h_fall && vcnt != CNT_MAX) begin
        vcnt <= vcnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      state <= CAP_SEEK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (v_fall) begin
      case (state)
        CAP_SEEK:    state_nxt = CAP_MEASURE;
        CAP_MEASURE: if (meas_match) state_nxt = CAP_LOCK;
        CAP_LOCK:    if (!meas_match) state_nxt = CAP_MEASURE;
        default:     state_nxt = CAP_SEEK;
      endcase
    end
  end

  assign locked = (state == CAP_LOCK);

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      prev_line_len    <= '0;
      prev_frame_lines <= '0;
      frame_done       <= 1'b0;
      frame_cnt        <= '0;
    end else begin
      frame_done <= v_fall && (state != CAP_SEEK);
      if (v_fall) begin
        prev_line_len    <= line_len_nxt;
        prev_frame_lines <= frame_lines_nxt;
        if (state != CAP_SEEK) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Sync-fall samples are blanking; the V-fall cycle also restarts the address.
  assign in_win  = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
  assign wr_qual = vid.pix_en && in_win && (state != CAP_SEEK) &&
                   !h_fall && !v_fall && !ptr_done;

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      wr_ptr      <= '0;
      ptr_done    <= 1'b0;
      vid.wr_en   <= 1'b0;
      vid.wr_addr <= '0;
      vid.wr_data <= '0;
    end else begin
      vid.wr_en <= wr_qual;
      if (v_fall) begin
        wr_ptr   <= '0;
        ptr_done <= 1'b0;
      end else if (wr_qual) begin
        vid.wr_addr <= wr_ptr;
        vid.wr_data <= pack_grb(vid.VIDEO_R, vid.VIDEO_G, vid.VIDEO_B);
        if (wr_ptr == ADDR_LAST) begin
          ptr_done <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_video_capture.sv
// Random-pixel bench for video_capture: frame-level reference model feeds two
// scoreboard queues (writes, frame events) drained by a negedge monitor.
module tb_video_capture;
  localparam int H_START = 2;
  localparam int H_LEN   = 4;
  localparam int V_START = 1;
  localparam int V_LEN   = 2;
  localparam int CNT_W   = 11;
  localparam int ADDR_W  = 16;
  localparam int LINES   = 5;
  localparam int LPIX    = 10;

  logic             clock = 1'b0;
  logic             reset_N;
  logic [CNT_W-1:0] line_len, frame_lines;
  logic             frame_done, locked;
  logic [7:0]       frame_cnt;

  always #5 clock = ~clock;

  video_capture_if #(.ADDR_W(ADDR_W)) vif ();

  video_capture #(
    .H_START (H_START), .H_LEN (H_LEN), .V_START (V_START), .V_LEN (V_LEN),
    .CNT_W   (CNT_W),   .ADDR_W (ADDR_W)
  ) dut (
    .clock       (clock),
    .reset_N     (reset_N),
    .vid         (vif),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .frame_done  (frame_done),
    .locked      (locked),
    .frame_cnt   (frame_cnt)
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic [8:0] data; } wr_exp_t;
  typedef struct { int lines; int len; bit lock; int cnt; } fr_exp_t;

  wr_exp_t wr_q[$];
  fr_exp_t fr_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: frame-level bookkeeping since the last V fall / reset.
  bit armed;
  int m_hf, m_pix, m_addr, m_cnt, prev_lines, prev_len;

  task automatic check(input string name, input longint act, input longint want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic model_reset();
    armed = 0; m_hf = 0; m_pix = 0; m_addr = 0; m_cnt = 0;
    prev_lines = 0; prev_len = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, vif.wr_en, 0);
    check({tag, "_wr_addr"}, vif.wr_addr, 0);
    check({tag, "_wr_data"}, vif.wr_data, 0);
    check({tag, "_line_len"}, line_len, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // One enabled pixel at (line l, pixel p) of a frame, then `gap` disabled cycles.
  task automatic emit(input int l, input int p, input int gap);
    logic [2:0] r, g, b;
    bit hf, vf, act;
    int lines, len;
    r = 3'($urandom); g = 3'($urandom); b = 3'($urandom);
    @(posedge clock); #1;
    vif.pix_en  = 1'b1;
    vif.HSYNC_n = (p != 0);
    vif.VSYNC_n = !(l == 0 && p == 0);
    vif.VIDEO_R = r; vif.VIDEO_G = g; vif.VIDEO_B = b;
    hf = (p == 0);
    vf = hf && (l == 0);
    // Pixel p>=1 sits at count p-1 after the H fall; line l at count l.
    act = armed && !hf && (p - 1 >= H_START) && (p - 1 < H_START + H_LEN) &&
          (l >= V_START) && (l < V_START + V_LEN) && (m_addr < H_LEN * V_LEN);
    if (act) begin
      wr_q.push_back('{ADDR_W'(m_addr), {g, r, b}});
      m_addr++;
    end
    if (vf) begin
      lines = m_hf + 1;
      len   = m_pix + 1;
      if (armed) begin
        m_cnt = (m_cnt + 1) % 256;
        fr_q.push_back('{lines, len, (lines == prev_lines && len == prev_len), m_cnt});
      end
      prev_lines = lines; prev_len = len;
      armed = 1; m_addr = 0; m_hf = 0;
    end
    if (hf) begin
      if (!vf) m_hf++;
      m_pix = 0;
    end else begin
      m_pix++;
    end
    repeat (gap) begin
      @(posedge clock); #1;
      vif.pix_en  = 1'b0;
      vif.HSYNC_n = 1'($urandom);
      vif.VSYNC_n = 1'($urandom);
      vif.VIDEO_R = 3'($urandom); vif.VIDEO_G = 3'($urandom); vif.VIDEO_B = 3'($urandom);
    end
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic run_frame(input int last_len, input int mode);
    for (int l = 0; l < LINES; l++) begin
      for (int p = 0; p < ((l == LINES - 1) ? last_len : LPIX); p++) begin
        emit(l, p, gap_for(mode));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      vif.pix_en = 1'b0;
    end
  endtask

  wr_exp_t mw;
  fr_exp_t mf;
  always @(negedge clock) begin
    if (vif.wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected", vif.wr_addr, vif.wr_data);
      end else begin
        mw = wr_q.pop_front();
        check("wr_addr", vif.wr_addr, mw.addr);
        check("wr_data", vif.wr_data, mw.data);
      end
    end
    if (frame_done === 1'b1) begin
      if (fr_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_frame_done: frame_cnt %0d, none expected", frame_cnt);
      end else begin
        mf = fr_q.pop_front();
        check("frame_lines", frame_lines, mf.lines);
        check("line_len", line_len, mf.len);
        check("locked", locked, mf.lock);
        check("frame_cnt", frame_cnt, mf.cnt);
      end
    end
  end

  initial begin
    reset_N     = 1'b0;
    vif.pix_en  = 1'b0;
    vif.HSYNC_n = 1'b1;
    vif.VSYNC_n = 1'b1;
    vif.VIDEO_R = '0; vif.VIDEO_G = '0; vif.VIDEO_B = '0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;
    reset_N = 1'b1;

    // Constant enable: seek, measure, lock.
    repeat (3) run_frame(LPIX, 0);
    // Shortened closing line breaks lock; two clean frames restore it.
    run_frame(LPIX - 1, 0);
    repeat (2) run_frame(LPIX, 0);
    // Alternating enable, then random enable gaps.
    repeat (2) run_frame(LPIX, 1);
    repeat (2) run_frame(LPIX, 2);

    // Mid-frame reset after part of line 1.
    for (int p = 0; p < LPIX; p++) emit(0, p, 0);
    for (int p = 0; p < 6; p++) emit(1, p, 0);
    @(posedge clock); #1;
    reset_N    = 1'b0;
    vif.pix_en = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check_zero("midreset");
    @(posedge clock); #1;
    reset_N = 1'b1;
    for (int p = 6; p < LPIX; p++) emit(1, p, 0);
    for (int l = 2; l < LINES; l++) begin
      for (int p = 0; p < LPIX; p++) emit(l, p, 0);
    end
    repeat (3) run_frame(LPIX, 0);
    emit(0, 0, 0);
    idle(6);

    check("wr_q_drained", wr_q.size(), 0);
    check("fr_q_drained", fr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
